// File: rtl/sd_route_pkg.sv
// Shared types and helpers for the SD-SPI router.
package sd_route_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } sd_route_state_e;

  localparam int unsigned SEL_PHYS = 0;

  // Width of the target select: physical card plus nslot virtual cards.
  function automatic int unsigned sel_width(input int unsigned nslot);
    int unsigned w;
    w = $clog2(nslot + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/sd_route_if.sv
// SD-SPI routing bus: core side, virtual card side, physical pins and status.
interface sd_route_if
  import sd_route_pkg::*;
#(
  parameter int unsigned NSLOT = 2,
  parameter int unsigned LANES = 8,
  parameter int unsigned SEL_W = sel_width(NSLOT)
);

  logic [NSLOT-1:0]       img_mounted;
  logic [NSLOT-1:0]       img_nonzero;
  logic                   sdss;
  logic                   sdclk;
  logic [LANES-1:0]       sdmosi;
  logic [LANES-1:0]       sdmiso;
  logic [NSLOT*LANES-1:0] vsd_miso;
  logic [NSLOT-1:0]       vsd_ss;
  logic                   sd_cs;
  logic                   sd_sck;
  logic                   sd_mosi;
  logic                   sd_miso;
  logic [SEL_W-1:0]       sel;
  logic                   switch_pending;
  logic                   sd_act;

  modport master (
    output img_mounted, img_nonzero, sdss, sdclk, sdmosi, vsd_miso, sd_miso,
    input  sdmiso, vsd_ss, sd_cs, sd_sck, sd_mosi, sel, switch_pending, sd_act
  );

  modport slave (
    input  img_mounted, img_nonzero, sdss, sdclk, sdmosi, vsd_miso, sd_miso,
    output sdmiso, vsd_ss, sd_cs, sd_sck, sd_mosi, sel, switch_pending, sd_act
  );

endinterface

// File: rtl/sd_act_stretch.sv
// SD activity detector: any sdclk toggle while selected restarts a saturating stretch counter.
module sd_act_stretch #(
  parameter int unsigned ACT_TIMEOUT = 1000000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic sdss_i,
  input  logic sdclk_i,
  output logic sd_act_o
);

  localparam int unsigned CNT_W = $clog2(ACT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACT_TIMEOUT);

  logic             sdclk_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             act_q;
  logic             toggle;

  assign toggle = (sdclk_i ^ sdclk_q) & ~sdss_i;

  always_comb begin
    cnt_d = cnt_q;
    if (toggle) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sdclk_q <= 1'b0;
      cnt_q   <= CNT_MAX;
      act_q   <= 1'b0;
    end else begin
      sdclk_q <= sdclk_i;
      cnt_q   <= cnt_d;
      act_q   <= (cnt_d < CNT_MAX);
    end
  end

  assign sd_act_o = act_q;

endmodule

// File: rtl/sd_route.sv
// SD-SPI router: one core master to the physical card or one of NSLOT virtual cards.
// Define SD_ROUTE_HOTSWAP_EN to defer target switches until the core deselects (sdss high).
module sd_route
  import sd_route_pkg::*;
#(
  parameter int unsigned NSLOT       = 2,
  parameter int unsigned LANES       = 8,
  parameter int unsigned ACT_TIMEOUT = 1000000
) (
  input  logic     clk_sys,
  input  logic     reset,
  sd_route_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(NSLOT);
  localparam logic [SEL_W-1:0] SEL_P = SEL_W'(SEL_PHYS);

  logic [SEL_W-1:0] sel_q;
  logic             pend_q;
  logic             req_vld;
  logic [SEL_W-1:0] req_tgt;
  logic [NSLOT-1:0] vss_c;
  logic [LANES-1:0] miso_c;
  logic             mosi_unused;

  // Mount arbiter: scan high to low so the lowest requesting slot wins.
  always_comb begin
    req_vld = 1'b0;
    req_tgt = SEL_P;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (bus.img_mounted[k]) begin
        if (bus.img_nonzero[k]) begin
          req_vld = 1'b1;
          req_tgt = SEL_W'(k + 1);
        end else if (sel_q == SEL_W'(k + 1)) begin
          req_vld = 1'b1;
          req_tgt = SEL_P;
        end
      end
    end
  end

`ifdef SD_ROUTE_HOTSWAP_EN
  sd_route_state_e  state_q;
  logic [SEL_W-1:0] tgt_q;

  // A late request while pending wins over applying the older target.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_P;
      tgt_q   <= SEL_P;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_vld && (req_tgt != sel_q)) begin
            tgt_q   <= req_tgt;
            pend_q  <= 1'b1;
            state_q <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (req_vld) begin
            tgt_q <= req_tgt;
          end else if (bus.sdss) begin
            sel_q   <= tgt_q;
            pend_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sel_q <= SEL_P;
    end else if (req_vld) begin
      sel_q <= req_tgt;
    end
  end

  assign pend_q = 1'b0;
`endif

  // Virtual selects and MISO return path follow the registered target.
  always_comb begin
    miso_c    = '1;
    miso_c[0] = bus.sd_miso;
    vss_c     = '1;
    for (int k = 0; k < NSLOT; k++) begin
      vss_c[k] = bus.sdss | (sel_q != SEL_W'(k + 1));
      if (sel_q == SEL_W'(k + 1)) begin
        miso_c = bus.vsd_miso[k*LANES +: LANES];
      end
    end
  end

  // The physical card is single-lane; upper MOSI lanes only reach virtual cards.
  assign mosi_unused = ^bus.sdmosi;

  assign bus.sd_cs          = bus.sdss | (sel_q != SEL_P);
  assign bus.sd_sck         = bus.sdclk & (sel_q == SEL_P);
  assign bus.sd_mosi        = bus.sdmosi[0] & (sel_q == SEL_P);
  assign bus.vsd_ss         = vss_c;
  assign bus.sdmiso         = miso_c;
  assign bus.sel            = sel_q;
  assign bus.switch_pending = pend_q;

  sd_act_stretch #(
    .ACT_TIMEOUT (ACT_TIMEOUT)
  ) u_act (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .sdss_i   (bus.sdss),
    .sdclk_i  (bus.sdclk),
    .sd_act_o (bus.sd_act)
  );

endmodule

// File: tb/tb_sd_route.sv
// Directed bench for sd_route (NSLOT=2, LANES=8, ACT_TIMEOUT=16); follows SD_ROUTE_HOTSWAP_EN.
module tb_sd_route;

  localparam int unsigned NSLOT = 2;
  localparam int unsigned LANES = 8;
  localparam int unsigned ACT_T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sd_route_if #(.NSLOT(NSLOT), .LANES(LANES)) bus ();

  sd_route #(
    .NSLOT       (NSLOT),
    .LANES       (LANES),
    .ACT_TIMEOUT (ACT_T)
  ) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [1:0]  mnt;
    logic [1:0]  nz;
    logic        ss;
    logic        ck;
    logic [7:0]  mosi;
    logic [15:0] vmiso;
    logic        pmiso;
    logic [1:0]  e_sel;
    logic        e_cs;
    logic        e_sck;
    logic        e_mosi;
    logic [1:0]  e_vss;
    logic [7:0]  e_miso;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.img_mounted = '0;
    bus.img_nonzero = '0;
    bus.sdss = 1'b1;
    bus.sdclk = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [1:0] mnt, input logic [1:0] nz);
    bus.img_mounted = mnt;
    bus.img_nonzero = nz;
  endtask

  initial begin
    int highs;

    bus.sdmosi   = '0;
    bus.vsd_miso = '0;
    bus.sd_miso  = 1'b0;
    do_reset();

    // Reset state
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_act", 32'(bus.sd_act), 32'd0);
    chk("rst_pend", 32'(bus.switch_pending), 32'd0);
    chk("rst_cs_hi", 32'(bus.sd_cs), 32'd1);
    chk("rst_vss_hi", 32'(bus.vsd_ss), 32'h3);
    bus.sdss = 1'b0;
    #1;
    chk("rst_cs_lo", 32'(bus.sd_cs), 32'd0);
    chk("rst_vss_lo", 32'(bus.vsd_ss), 32'h3);

    //           mnt    nz     ss    ck    mosi   vmiso     pm    sel    cs    sck   smosi vss    miso
    tbl[0]  = '{2'b00, 2'b00, 1'b0, 1'b1, 8'h01, 16'hA55A, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'b11, 8'hFE};
    tbl[1]  = '{2'b00, 2'b00, 1'b1, 1'b0, 8'hFE, 16'hA55A, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2'b11, 8'hFF};
    tbl[2]  = '{2'b10, 2'b10, 1'b1, 1'b1, 8'h01, 16'hC33C, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'b11, 8'hC3};
    tbl[3]  = '{2'b00, 2'b00, 1'b0, 1'b1, 8'h01, 16'h1234, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 2'b01, 8'h12};
    tbl[4]  = '{2'b01, 2'b00, 1'b1, 1'b0, 8'h01, 16'h5678, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'b11, 8'h56};
    tbl[5]  = '{2'b11, 2'b11, 1'b1, 1'b0, 8'hFF, 16'h9ABC, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'b11, 8'hBC};
    tbl[6]  = '{2'b00, 2'b00, 1'b0, 1'b1, 8'h01, 16'hDEF0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'b10, 8'hF0};
    tbl[7]  = '{2'b10, 2'b00, 1'b1, 1'b0, 8'h01, 16'h0F0E, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'b11, 8'h0E};
    tbl[8]  = '{2'b01, 2'b00, 1'b1, 1'b1, 8'h01, 16'hFFFF, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 2'b11, 8'hFF};
    tbl[9]  = '{2'b11, 2'b01, 1'b1, 1'b0, 8'h00, 16'h00AA, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'b11, 8'hAA};
    tbl[10] = '{2'b11, 2'b10, 1'b1, 1'b0, 8'h01, 16'h3344, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'b11, 8'hFE};
    tbl[11] = '{2'b01, 2'b00, 1'b0, 1'b0, 8'h01, 16'h5566, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'b11, 8'hFF};

    // Each row: one cycle with the mount pulse, one settle cycle, then compare.
    for (int i = 0; i < 12; i++) begin
      pulse(tbl[i].mnt, tbl[i].nz);
      bus.sdss     = tbl[i].ss;
      bus.sdclk    = tbl[i].ck;
      bus.sdmosi   = tbl[i].mosi;
      bus.vsd_miso = tbl[i].vmiso;
      bus.sd_miso  = tbl[i].pmiso;
      tick();
      pulse(2'b00, 2'b00);
      tick();
      chk($sformatf("v%0d_sel", i), 32'(bus.sel), 32'(tbl[i].e_sel));
      chk($sformatf("v%0d_pend", i), 32'(bus.switch_pending), 32'd0);
      chk($sformatf("v%0d_cs", i), 32'(bus.sd_cs), 32'(tbl[i].e_cs));
      chk($sformatf("v%0d_sck", i), 32'(bus.sd_sck), 32'(tbl[i].e_sck));
      chk($sformatf("v%0d_mosi", i), 32'(bus.sd_mosi), 32'(tbl[i].e_mosi));
      chk($sformatf("v%0d_vss", i), 32'(bus.vsd_ss), 32'(tbl[i].e_vss));
      chk($sformatf("v%0d_miso", i), 32'(bus.sdmiso), 32'(tbl[i].e_miso));
    end

`ifdef SD_ROUTE_HOTSWAP_EN
    // Switch deferred while the bus stays selected
    do_reset();
    bus.sdss = 1'b0;
    pulse(2'b01, 2'b01);
    tick();
    pulse(2'b00, 2'b00);
    chk("hs_e0_pend", 32'(bus.switch_pending), 32'd1);
    chk("hs_e0_sel", 32'(bus.sel), 32'd0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("hs_hold_sel", 32'(bus.sel), 32'd0);
      chk("hs_hold_pend", 32'(bus.switch_pending), 32'd1);
    end
    bus.sdss = 1'b1;
    tick();
    chk("hs_apply_sel", 32'(bus.sel), 32'd1);
    chk("hs_apply_pend", 32'(bus.switch_pending), 32'd0);

    // Request and bus idle on the same edge: retarget, apply one edge later
    bus.sdss = 1'b0;
    pulse(2'b10, 2'b10);
    tick();
    chk("hs_same_pend0", 32'(bus.switch_pending), 32'd1);
    bus.sdss = 1'b1;
    pulse(2'b01, 2'b00);
    tick();
    pulse(2'b00, 2'b00);
    chk("hs_same_sel1", 32'(bus.sel), 32'd1);
    chk("hs_same_pend1", 32'(bus.switch_pending), 32'd1);
    tick();
    chk("hs_same_sel2", 32'(bus.sel), 32'd0);
    chk("hs_same_pend2", 32'(bus.switch_pending), 32'd0);

    // Reset while pending discards the request
    bus.sdss = 1'b0;
    pulse(2'b10, 2'b10);
    tick();
    pulse(2'b00, 2'b00);
    chk("hs_rst_pend0", 32'(bus.switch_pending), 32'd1);
    rst = 1'b1;
    bus.sdss = 1'b1;
    tick();
    rst = 1'b0;
    chk("hs_rst_sel", 32'(bus.sel), 32'd0);
    chk("hs_rst_pend", 32'(bus.switch_pending), 32'd0);
    tick();
    chk("hs_rst_sel2", 32'(bus.sel), 32'd0);
`else
    // Immediate switch even with the bus selected
    do_reset();
    bus.sdss = 1'b0;
    pulse(2'b01, 2'b01);
    tick();
    pulse(2'b00, 2'b00);
    chk("nh_e0_sel", 32'(bus.sel), 32'd1);
    chk("nh_e0_pend", 32'(bus.switch_pending), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nh_hold_pend", 32'(bus.switch_pending), 32'd0);
      chk("nh_hold_sel", 32'(bus.sel), 32'd1);
    end
`endif

    // Activity stretch: a single qualifying toggle
    do_reset();
    bus.sdss = 1'b0;
    tick();
    tick();
    chk("act_idle", 32'(bus.sd_act), 32'd0);
    bus.sdclk = 1'b1;
    tick();
    chk("act_rise", 32'(bus.sd_act), 32'd1);
    highs = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.sd_act) highs++;
    end
    chk("act_width", 32'(highs), 32'(ACT_T));

    // Toggle while deselected is not activity
    bus.sdss = 1'b1;
    bus.sdclk = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.sd_act) highs++;
    end
    chk("act_desel", 32'(highs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_route.md
# sd_route

Parametrised SD-SPI router between the core's single SD master and one physical SD card plus `NSLOT` virtual (image-backed) SD cards. It tracks per-slot image mount/unmount events, selects the active target and switches only between SPI transactions. It also produces a stretched activity flag for the LED. It sits in `emu` between `zxnext_top` SD pins, the `sd_card` instances and the `SD_*` top-level pins.

## Interface
Parameters:
- `NSLOT`, 2, number of virtual SD slots (1..7)
- `LANES`, 8, MOSI/MISO bus width (octal-capable core)
- `ACT_TIMEOUT`, 1000000, activity stretch length in `clk_sys` cycles

Ports (one clock `clk_sys`; `reset` synchronous, active-high):
- `clk_sys` in 1 system clock
- `reset` in 1 synchronous active-high reset
- `img_mounted` in NSLOT one-cycle mount pulse per slot
- `img_nonzero` in NSLOT per-slot `|img_size`, valid with pulse
- `sdss` in 1 core chip select, active low
- `sdclk` in 1 core SPI clock
- `sdmosi` in LANES core MOSI
- `sdmiso` out LANES MISO returned to core
- `vsd_miso` in NSLOT*LANES MISO from virtual cards, slot k at [k*LANES +: LANES]
- `vsd_ss` out NSLOT per-slot select to `sd_card`, active low
- `sd_cs` out 1 physical CS
- `sd_sck` out 1 physical SCK
- `sd_mosi` out 1 physical MOSI
- `sd_miso` in 1 physical MISO
- `sel` out $clog2(NSLOT+1) target: 0 physical, k = slot k-1
- `switch_pending` out 1 request waiting for bus idle
- `sd_act` out 1 stretched activity

## Operation
- Request generation per cycle, lowest-index pulsing slot wins: nonzero mount of slot k -> request k+1; zero-size mount of slot k when `sel`==k+1 -> request 0; zero-size mount of a non-selected slot -> ignored.
- FSM (with hotswap): IDLE -> PEND on request (latch target). PEND: new request overwrites target; at edge with `sdss`==1 sampled, `sel`<=target, -> IDLE. Request equal to current `sel` in IDLE -> no transition.
- Routing (combinational from registered `sel`): `sd_cs`=`sdss`|(`sel`!=0); `sd_sck`=`sdclk`&(`sel`==0); `sd_mosi`=`sdmosi[0]`&(`sel`==0); `vsd_ss[k]`=`sdss`|(`sel`!=k+1); `sdmiso`=`sel`==0 ? {all-ones, `sd_miso`} : `vsd_miso` slot `sel`-1.
- Activity: counter, width $clog2(ACT_TIMEOUT+1), saturates at ACT_TIMEOUT; cleared when `sdclk` toggles (vs. previous sample) while `sdss`==0; `sd_act`=counter<ACT_TIMEOUT, registered.

## Timing
- Reset: `sel`=0, FSM IDLE, `switch_pending`=0, counter=ACT_TIMEOUT, `sd_act`=0, sdclk history=0.
- Request sampled at edge E0 -> `switch_pending`=1 after E0; earliest `sel` update at E1 (if `sdss` high in cycle after E0); `switch_pending` drops same edge.
- `sdss` held low indefinitely -> `sel` frozen, `switch_pending` stays 1.
- Request and bus-idle apply on same edge in PEND: new target latched, apply deferred one edge.
- `sd_act` rises one edge after the qualifying toggle; falls exactly ACT_TIMEOUT edges after the last one.
- Reset mid-PEND: request discarded, `sel`=0.

## Configuration
- `SD_ROUTE_HOTSWAP_EN` defined: FSM above; switching deferred to `sdss` high.
- Undefined: no PEND state; `sel` loads request at E0; `switch_pending` tied 0.

## Structure
- `sd_route_pkg`: FSM state enum (`ST_IDLE`, `ST_PEND`), `SEL_PHYS`=0, function computing sel width from NSLOT.
- Sub-module `sd_act_stretch` (toggle detect + saturating counter, params ACT_TIMEOUT); router, request arbiter and muxes in `sd_route`.

## Test plan
- Reset, NSLOT=2: `sel`=0, `sd_act`=0, `sd_cs` follows `sdss`, `vsd_ss`=2'b11.
- Mount slot 1 nonzero with `sdss`=1 -> `sel`=2 at E1; `sdmiso`=`vsd_miso[15:8]`; `sd_sck` forced 0.
- Mount slot 0 nonzero while `sdss`=0 for 50 cycles -> `switch_pending`=1, `sel` unchanged until first edge after `sdss` rises.
- Simultaneous pulses slots 0 and 1 nonzero -> `sel`=1; then zero-size pulse on slot 1 -> no change; zero-size on slot 0 -> `sel`=0.
- ACT_TIMEOUT=16: one `sdclk` toggle with `sdss`=0 -> `sd_act` high 16 cycles; toggle with `sdss`=1 -> stays 0.
- Hotswap undefined: mount with `sdss`=0 -> `sel` updates at E0, `switch_pending` never 1.
